// File: rtl/process_dispatch_queue.sv
// Descriptor FIFO between the process control block and the kernel array.
// Each queued descriptor is dispatched to the kernel that is granted for it.
module process_dispatch_queue #(
    parameter int KERNEL_NUM = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          process_start,
    input  logic [87:0]                   process_info,
    output logic                          process_accept,
    input  logic                          new_dsc,
    output logic                          engine_start,
    input  logic [KERNEL_NUM-1:0]         kernel_start,
    output logic [KERNEL_NUM-1:0]         dsc_valid,
    output logic [63:0]                   dsc_addr,
    output logic [8:0]                    dsc_pid,
    output logic [7:0]                    dsc_ctrl,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          grant_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, GAP} state_t;

    state_t                state;
    logic [80:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [80:0]           head;
    logic                  push;
    logic                  pop;
    logic                  grant_any;
    logic                  grant_multi;
    logic [KERNEL_NUM-1:0] grant_low;
    logic                  unused_pad;

    // Holding off while process_accept is high stops a second capture of the same offer.
    always_comb begin
        push        = process_start && !process_accept && (count < CW'(FIFO_DEPTH));
        grant_any   = (kernel_start != '0);
        grant_multi = ((kernel_start & (kernel_start - 1'b1)) != '0);
        grant_low   = kernel_start & (~kernel_start + 1'b1);
        pop         = (state == CHECK) && grant_any;
        head        = mem[rd_ptr];
        fifo_count  = count;
        unused_pad  = ^process_info[87:81];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= process_info[80:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            process_accept <= 1'b0;
        end else begin
            process_accept <= push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            engine_start <= 1'b0;
            dsc_valid    <= '0;
            dsc_addr     <= '0;
            dsc_pid      <= '0;
            dsc_ctrl     <= '0;
            grant_err    <= 1'b0;
        end else begin
            engine_start <= 1'b0;
            dsc_valid    <= '0;
            case (state)
                IDLE: begin
                    if ((count != '0) && new_dsc) begin
                        state        <= ISSUE;
                        engine_start <= 1'b1;
                    end
                end
                ISSUE: state <= CHECK;
                CHECK: begin
                    // A zero grant leaves the head in place so it is retried on the next pass.
                    if (grant_any) begin
                        dsc_valid <= grant_low;
                        dsc_addr  <= head[63:0];
                        dsc_pid   <= head[72:64];
                        dsc_ctrl  <= head[80:73];
                        if (grant_multi) begin
                            grant_err <= 1'b1;
                        end
                    end
                    state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_process_dispatch_queue.sv
// Directed bench for process_dispatch_queue: a kernel-grant responder, a
// scoreboard of expected descriptors and a monitor comparing every dsc_valid.
module tb_process_dispatch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        process_start = 1'b0;
    logic [87:0] process_info = '0;
    logic        process_accept;
    logic        new_dsc = 1'b0;
    logic        engine_start;
    logic [7:0]  kernel_start;
    logic [7:0]  dsc_valid;
    logic [63:0] dsc_addr;
    logic [8:0]  dsc_pid;
    logic [7:0]  dsc_ctrl;
    logic [4:0]  fifo_count;
    logic        grant_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  grant_val   = '0;
    logic [7:0]  exp_onehot  = '0;
    logic [80:0] exp_dsc [$];
    logic [7:0]  exp_vld [$];

    process_dispatch_queue #(.KERNEL_NUM(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .process_start(process_start), .process_info(process_info),
        .process_accept(process_accept), .new_dsc(new_dsc),
        .engine_start(engine_start), .kernel_start(kernel_start),
        .dsc_valid(dsc_valid), .dsc_addr(dsc_addr), .dsc_pid(dsc_pid),
        .dsc_ctrl(dsc_ctrl), .fifo_count(fifo_count), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control-block model: grant driven for the whole cycle after engine_start.
    initial begin
        logic pend;
        pend = 1'b0;
        kernel_start = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                kernel_start = '0;
                pend = 1'b0;
            end else begin
                kernel_start = pend ? grant_val : '0;
                if (pend && grant_val != '0) exp_vld.push_back(exp_onehot);
                pend = engine_start;
            end
        end
    end

    initial begin
        logic [80:0] e;
        logic [7:0]  v;
        forever begin
            @(negedge clk);
            if (dsc_valid != '0) begin
                if (exp_dsc.size() == 0 || exp_vld.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_dsc_valid: got %0h expected none", dsc_valid);
                end else begin
                    e = exp_dsc.pop_front();
                    v = exp_vld.pop_front();
                    check("dsc_valid", dsc_valid, v);
                    check("dsc_fields", {dsc_ctrl, dsc_pid, dsc_addr}, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic offer(input logic [8:0] pid, input logic [63:0] addr, input logic [7:0] ctrl);
        int w;
        process_info  = {7'b0, ctrl, pid, addr};
        process_start = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (!process_accept && w < 200);
        if (!process_accept) check("accept_timeout", 1'b0, 1'b1);
        else exp_dsc.push_back({ctrl, pid, addr});
        process_start = 1'b0;
    endtask

    task automatic wait_engine();
        int w;
        w = 0;
        while (!engine_start && w < 50) begin
            tick();
            w++;
        end
        if (!engine_start) check("engine_start_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_empty(input int limit);
        int w;
        w = 0;
        while (fifo_count != 0 && w < limit) begin
            tick();
            w++;
        end
        if (fifo_count != 0) check("drain_timeout", fifo_count, 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {process_accept, engine_start, dsc_valid, dsc_addr, dsc_pid,
                     dsc_ctrl, fifo_count, grant_err}, '0);
    endtask

    initial begin
        int  busy;
        logic seen;

        // 1: reset, single dispatch with latency check
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_outputs");
        exp_dsc.delete();
        exp_vld.delete();
        rst = 1'b0;
        tick();
        offer(9'd5, 64'h1000_0000_0000_0040, 8'h3C);
        check("t1_count_after_push", fifo_count, 1);
        grant_val  = 8'h80;
        exp_onehot = 8'h80;
        new_dsc    = 1'b1;
        tick();
        check("t1_engine_start", engine_start, 1'b1);
        new_dsc = 1'b0;
        tick();
        check("t1_engine_start_pulse", engine_start, 1'b0);
        tick();
        check("t1_dsc_valid_latency", dsc_valid, 8'h80);
        check("t1_count_after_pop", fifo_count, 0);
        tick();
        tick();

        // 2: fill to 16, 17th waits for a dispatch
        for (int i = 0; i < 16; i++) offer(9'(i + 16), 64'hA000 + 64'(i), 8'(i));
        check("t2_count_full", fifo_count, 16);
        process_info  = {7'b0, 8'hEE, 9'd200, 64'hBEEF_0000_0000_0017};
        process_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (process_accept) seen = 1'b1;
        end
        check("t2_full_no_accept", seen, 1'b0);
        check("t2_count_still_full", fifo_count, 16);
        grant_val  = 8'h01;
        exp_onehot = 8'h01;
        new_dsc    = 1'b1;
        wait_engine();
        new_dsc = 1'b0;
        busy = 0;
        while (!process_accept && busy < 20) begin
            tick();
            busy++;
        end
        if (!process_accept) check("t2_late_accept_timeout", 1'b0, 1'b1);
        else exp_dsc.push_back({8'hEE, 9'd200, 64'hBEEF_0000_0000_0017});
        process_start = 1'b0;
        check("t2_count_refilled", fifo_count, 16);
        new_dsc = 1'b1;
        wait_empty(300);
        new_dsc = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t2_scoreboard_empty", exp_dsc.size(), 0);

        // 3: zero grant, entry retried on the next pass (ISSUE/CHECK/GAP/IDLE period)
        offer(9'd33, 64'h3333_0000, 8'h33);
        grant_val = 8'h00;
        new_dsc   = 1'b1;
        wait_engine();
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4 && engine_start) seen = 1'b1;
            if (k == 3) check("t3_count_unchanged", fifo_count, 1);
        end
        check("t3_no_early_repulse", seen, 1'b0);
        check("t3_engine_repulse", engine_start, 1'b1);
        grant_val  = 8'h10;
        exp_onehot = 8'h10;
        new_dsc    = 1'b0;
        wait_empty(20);
        tick();
        tick();

        // 4: push coincident with pop, then many pointer wraps
        for (int i = 0; i < 3; i++) offer(9'(100 + i), 64'h4000 + 64'(i), 8'h40);
        grant_val  = 8'h04;
        exp_onehot = 8'h04;
        new_dsc    = 1'b1;
        wait_engine();
        new_dsc = 1'b0;
        tick();
        process_info  = {7'b0, 8'h41, 9'd103, 64'h4003};
        process_start = 1'b1;
        tick();
        check("t4_coincident_accept", process_accept, 1'b1);
        check("t4_coincident_count", fifo_count, 3);
        check("t4_coincident_dsc_valid", dsc_valid, 8'h04);
        exp_dsc.push_back({8'h41, 9'd103, 64'h4003});
        process_start = 1'b0;
        grant_val  = 8'h20;
        exp_onehot = 8'h20;
        new_dsc    = 1'b1;
        for (int i = 0; i < 330; i++) offer(9'(i), {32'hC0DE, 32'(i)}, 8'(i * 3));
        wait_empty(400);
        new_dsc = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_scoreboard_empty", exp_dsc.size(), 0);

        // 5: multi-bit grant
        check("t5_grant_err_clear", grant_err, 1'b0);
        offer(9'd7, 64'h5555_AAAA, 8'h55);
        grant_val  = 8'h06;
        exp_onehot = 8'h02;
        new_dsc    = 1'b1;
        wait_empty(20);
        new_dsc = 1'b0;
        tick();
        check("t5_grant_err_set", grant_err, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_grant_err_sticky", grant_err, 1'b1);

        // 6: reset during ISSUE with 4 queued
        for (int i = 0; i < 4; i++) offer(9'(60 + i), 64'h6000 + 64'(i), 8'h66);
        check("t6_count_before_reset", fifo_count, 4);
        grant_val  = 8'h01;
        exp_onehot = 8'h01;
        new_dsc    = 1'b1;
        wait_engine();
        rst = 1'b1;
        tick();
        check_all_zero("t6_reset_outputs");
        exp_dsc.delete();
        exp_vld.delete();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dsc_valid != '0 || engine_start || fifo_count != 0) seen = 1'b1;
        end
        check("t6_no_stale_dispatch", seen, 1'b0);
        check("t6_grant_err_cleared", grant_err, 1'b0);
        new_dsc = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
